ndn_lookup_arbiter: RTL and testbench
=====================================

Name: ndn_lookup_arbiter

Overview:
- Shares one ndn prefix-lookup core between two requesters: the MCU-side SPI front end and the interface-side SPI front end.
- Round-robin grants; drives the core's prefix/len; issues the single-cycle out_bit strobe; waits for core completion; returns the content result to the granted requester.
- Sits between the two SPI front ends and the ndn core, as the core's only sequencer.

Parameters:
- PREFIX_W, 64, prefix width in bits
- LEN_W, 5, prefix-length field width
- CONTENT_W, 64, core content result width
- CLEN_W, 8, content-length field width
- TIMEOUT_CYCLES, 1023, maximum WAIT cycles before abort (used only with the optional feature)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- mcu_req_valid  in  1  MCU lookup request
- mcu_req_ready  out  1  MCU request accepted this cycle
- mcu_prefix  in  PREFIX_W  MCU prefix
- mcu_len  in  LEN_W  MCU prefix length
- if_req_valid  in  1  interface lookup request
- if_req_ready  out  1  interface request accepted this cycle
- if_prefix  in  PREFIX_W  interface prefix
- if_len  in  LEN_W  interface prefix length
- core_prefix  out  PREFIX_W  registered prefix to core
- core_len  out  LEN_W  registered length to core
- core_out_bit  out  1  one-cycle start strobe to core
- core_done  in  1  core completion strobe
- core_content  in  CONTENT_W  core result, valid with core_done
- core_content_len  in  CLEN_W  result length, valid with core_done
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer ready
- rsp_dest  out  1  0 = MCU, 1 = interface
- rsp_content  out  CONTENT_W  latched result
- rsp_content_len  out  CLEN_W  latched result length
- rsp_timeout  out  1  response is a timeout abort

Behaviour:
- Reset values:
  - All outputs 0; state IDLE.
  - last_grant = 1, so the MCU wins the first tie.
  - Reset in any state aborts the transaction: no response and no out_bit the following cycle.
- States:
  - IDLE -> ISSUE on accept.
  - ISSUE -> WAIT unconditionally.
  - WAIT -> RESPOND on core_done (or timeout).
  - RESPOND -> IDLE on rsp_valid && rsp_ready.
- Grant in IDLE:
  - Only one valid: that requester wins.
  - Both valid: the requester not equal to last_grant wins.
  - Ready is combinational and asserted only for the winner while in IDLE; at most one ready is high per cycle.
- Accept:
  - Occurs on valid && ready.
  - Latch prefix/len into core_prefix/core_len and the winner id into rsp_dest.
  - Update last_grant to the winner.
- Requester rules:
  - A requester holds valid, prefix and len stable until ready.
  - Dropping valid before ready is permitted; no grant is lost.
- ISSUE: core_out_bit = 1 for exactly this one cycle. core_prefix/core_len stay stable from ISSUE through the end of WAIT.
- WAIT:
  - core_done is sampled only in WAIT; a core_done in IDLE, ISSUE or RESPOND is ignored.
  - On core_done, capture core_content and core_content_len; rsp_timeout = 0.
- RESPOND:
  - rsp_valid is held with all rsp_* fields stable until rsp_ready.
  - No new request is accepted until the cycle after the handshake; ready is never asserted in RESPOND.
- Latency: accept at cycle T; out_bit at T+1; core_done at cycle D >= T+2 gives rsp_valid at D+1. Minimum accept-to-response is 3 cycles.
- Back-to-back: after the rsp handshake at cycle R, the earliest next accept is R+1.

Optional Feature:
- Macro: NDN_ARB_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to WAIT and increments each WAIT cycle.
  - Reaching TIMEOUT_CYCLES without core_done forces RESPOND with rsp_timeout = 1 and rsp_content/rsp_content_len = 0.
  - core_done on the same cycle as the counter limit takes priority, giving a normal response.
- Undefined: no counter; WAIT is held indefinitely; rsp_timeout is tied to 0.

Decomposition:
- Shared package ndn_pkg:
  - state enum (IDLE/ISSUE/WAIT/RESPOND)
  - requester id constants REQ_MCU = 0, REQ_IF = 1
  - default widths PREFIX_W/LEN_W/CONTENT_W/CLEN_W
- One natural sub-module: ndn_rr_arbiter2, a 2-way round-robin grant with last_grant register.
- FSM and datapath stay in the top.

Test Plan:
- Single MCU request, prefix = 28, len = 5; core_done 4 cycles after out_bit with content 0xAB and len 8 -> exactly one out_bit pulse; rsp_dest = 0, content 0xAB, len 8; rsp_valid held while rsp_ready = 0 for 3 cycles.
- Both requesters valid continuously for 4 transactions -> grants MCU, IF, MCU, IF; rsp_dest alternates 0, 1, 0, 1.
- core_done pulsed during IDLE and during ISSUE -> ignored; FSM still waits for a core_done in WAIT.
- Reset asserted in WAIT -> next cycle all outputs 0, state IDLE, no rsp_valid; a subsequent request proceeds normally.
- With NDN_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, no core_done -> rsp_valid with rsp_timeout = 1 and content 0, 16 cycles after WAIT entry. Same case without the macro -> stays in WAIT for 100 cycles.
- core_done on the exact timeout cycle (macro defined) -> normal response, rsp_timeout = 0, captured content.

Source files
------------

// File: rtl/ndn_pkg.sv
// ============================================================================
//  Package     : ndn_pkg
//  Description : Shared types and constants for the ndn lookup arbiter:
//                sequencer state encoding, requester ids, default widths.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ndn_pkg;

    // Sequencer states of the lookup arbiter
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RESPOND = 2'd3
    } ndn_state_t;

    // Requester ids (also the encoding of rsp_dest)
    localparam logic REQ_MCU = 1'b0;
    localparam logic REQ_IF  = 1'b1;

    // Default datapath widths
    localparam int DEF_PREFIX_W  = 64;
    localparam int DEF_LEN_W     = 5;
    localparam int DEF_CONTENT_W = 64;
    localparam int DEF_CLEN_W    = 8;

endpackage : ndn_pkg

`default_nettype wire

// File: rtl/ndn_rr_arbiter2.sv
// ============================================================================
//  Module      : ndn_rr_arbiter2
//  Description : Two-way round-robin grant. A lone requester always wins;
//                on a tie the requester that did not win last time wins.
//                Ready is combinational and only raised while enabled.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ndn_rr_arbiter2
    import ndn_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_valid_mcu,
    input  logic i_valid_if,
    output logic o_ready_mcu,
    output logic o_ready_if,
    output logic o_winner,
    output logic o_accept
);

    logic r_last_grant;
    logic w_winner;
    logic w_accept;

    // Pick the winner and raise ready only for it while enabled
    always_comb begin
        if (i_valid_mcu && i_valid_if) begin
            w_winner = ~r_last_grant;
        end else if (i_valid_if) begin
            w_winner = REQ_IF;
        end else begin
            w_winner = REQ_MCU;
        end
        w_accept    = i_enable && (i_valid_mcu || i_valid_if);
        o_ready_mcu = w_accept && (w_winner == REQ_MCU);
        o_ready_if  = w_accept && (w_winner == REQ_IF);
        o_winner    = w_winner;
        o_accept    = w_accept;
    end

    // Remember who was granted; reset favours the MCU on the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= REQ_IF;
        end else if (w_accept) begin
            r_last_grant <= w_winner;
        end
    end

endmodule : ndn_rr_arbiter2

`default_nettype wire

// File: rtl/ndn_lookup_arbiter.sv
// ============================================================================
//  Module      : ndn_lookup_arbiter
//  Description : Shares one ndn prefix-lookup core between the MCU-side and
//                interface-side SPI front ends. Grants round-robin, drives
//                the core prefix/len, strobes core_out_bit for one cycle,
//                waits for core_done and returns the result to the winner.
//                Optional macro NDN_ARB_TIMEOUT_EN adds a WAIT-state abort
//                after TIMEOUT_CYCLES cycles without core_done.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ndn_lookup_arbiter
    import ndn_pkg::*;
#(
    parameter int PREFIX_W       = DEF_PREFIX_W,
    parameter int LEN_W          = DEF_LEN_W,
    parameter int CONTENT_W      = DEF_CONTENT_W,
    parameter int CLEN_W         = DEF_CLEN_W,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mcu_req_valid,
    output logic                 mcu_req_ready,
    input  logic [PREFIX_W-1:0]  mcu_prefix,
    input  logic [LEN_W-1:0]     mcu_len,
    input  logic                 if_req_valid,
    output logic                 if_req_ready,
    input  logic [PREFIX_W-1:0]  if_prefix,
    input  logic [LEN_W-1:0]     if_len,
    output logic [PREFIX_W-1:0]  core_prefix,
    output logic [LEN_W-1:0]     core_len,
    output logic                 core_out_bit,
    input  logic                 core_done,
    input  logic [CONTENT_W-1:0] core_content,
    input  logic [CLEN_W-1:0]    core_content_len,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_dest,
    output logic [CONTENT_W-1:0] rsp_content,
    output logic [CLEN_W-1:0]    rsp_content_len,
    output logic                 rsp_timeout
);

    // A zero timeout would make the WAIT abort meaningless
    generate
        if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout_cfg
            $error("ndn_lookup_arbiter: TIMEOUT_CYCLES must be at least 1");
        end
    endgenerate

    ndn_state_t r_state;
    ndn_state_t w_state_nxt;

    logic w_idle;
    logic w_winner;
    logic w_accept;
    logic w_done_take;
    logic w_timeout_hit;

    assign w_idle      = (r_state == ST_IDLE);
    // core_done is only meaningful while the core is actually working
    assign w_done_take = (r_state == ST_WAIT) && core_done;

    ndn_rr_arbiter2 u_rr_arbiter2 (
        .clk         (clk),
        .rst         (rst),
        .i_enable    (w_idle),
        .i_valid_mcu (mcu_req_valid),
        .i_valid_if  (if_req_valid),
        .o_ready_mcu (mcu_req_ready),
        .o_ready_if  (if_req_ready),
        .o_winner    (w_winner),
        .o_accept    (w_accept)
    );

`ifdef NDN_ARB_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_rsp_timeout;

    // Counts WAIT cycles; cleared in ISSUE so it starts at zero on WAIT entry
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_ISSUE) begin
            r_wait_cnt <= '0;
        end else if (r_state == ST_WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Abort on the last allowed WAIT cycle; a simultaneous core_done wins
    assign w_timeout_hit = (r_state == ST_WAIT) && !core_done &&
                           (r_wait_cnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

    // Flags whether the pending response is an abort or a real result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_timeout <= 1'b0;
        end else if (w_done_take) begin
            r_rsp_timeout <= 1'b0;
        end else if (w_timeout_hit) begin
            r_rsp_timeout <= 1'b1;
        end
    end

    assign rsp_timeout = r_rsp_timeout;
`else
    assign w_timeout_hit = 1'b0;
    assign rsp_timeout   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (w_done_take || w_timeout_hit) begin
                    w_state_nxt = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State-decoded outputs: start strobe and response valid
    always_comb begin
        core_out_bit = (r_state == ST_ISSUE);
        rsp_valid    = (r_state == ST_RESPOND);
    end

    // Request capture on accept and result capture at the end of WAIT
    always_ff @(posedge clk) begin
        if (rst) begin
            core_prefix     <= '0;
            core_len        <= '0;
            rsp_dest        <= 1'b0;
            rsp_content     <= '0;
            rsp_content_len <= '0;
        end else begin
            if (w_accept) begin
                core_prefix <= (w_winner == REQ_IF) ? if_prefix : mcu_prefix;
                core_len    <= (w_winner == REQ_IF) ? if_len    : mcu_len;
                rsp_dest    <= w_winner;
            end
            if (w_done_take) begin
                rsp_content     <= core_content;
                rsp_content_len <= core_content_len;
            end else if (w_timeout_hit) begin
                rsp_content     <= '0;
                rsp_content_len <= '0;
            end
        end
    end

endmodule : ndn_lookup_arbiter

`default_nettype wire

// File: tb/tb_ndn_lookup_arbiter.sv
// ============================================================================
//  Module      : tb_ndn_lookup_arbiter
//  Description : Self-checking bench for ndn_lookup_arbiter. Directed steps
//                followed by randomized transactions, checked against a
//                transaction-level model of the grant/latency rules.
//                Honours NDN_ARB_TIMEOUT_EN (uses TIMEOUT_CYCLES = 16).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ndn_lookup_arbiter;

    localparam int PW  = 64;
    localparam int LW  = 5;
    localparam int CW  = 64;
    localparam int CLW = 8;
`ifdef NDN_ARB_TIMEOUT_EN
    localparam int TMO    = 16;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 1023;
    localparam bit TMO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           mcu_req_valid = 1'b0;
    logic           mcu_req_ready;
    logic [PW-1:0]  mcu_prefix = '0;
    logic [LW-1:0]  mcu_len = '0;
    logic           if_req_valid = 1'b0;
    logic           if_req_ready;
    logic [PW-1:0]  if_prefix = '0;
    logic [LW-1:0]  if_len = '0;
    logic [PW-1:0]  core_prefix;
    logic [LW-1:0]  core_len;
    logic           core_out_bit;
    logic           core_done = 1'b0;
    logic [CW-1:0]  core_content = '0;
    logic [CLW-1:0] core_content_len = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b0;
    logic           rsp_dest;
    logic [CW-1:0]  rsp_content;
    logic [CLW-1:0] rsp_content_len;
    logic           rsp_timeout;

    ndn_lookup_arbiter #(
        .PREFIX_W       (PW),
        .LEN_W          (LW),
        .CONTENT_W      (CW),
        .CLEN_W         (CLW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .mcu_req_valid    (mcu_req_valid),
        .mcu_req_ready    (mcu_req_ready),
        .mcu_prefix       (mcu_prefix),
        .mcu_len          (mcu_len),
        .if_req_valid     (if_req_valid),
        .if_req_ready     (if_req_ready),
        .if_prefix        (if_prefix),
        .if_len           (if_len),
        .core_prefix      (core_prefix),
        .core_len         (core_len),
        .core_out_bit     (core_out_bit),
        .core_done        (core_done),
        .core_content     (core_content),
        .core_content_len (core_content_len),
        .rsp_valid        (rsp_valid),
        .rsp_ready        (rsp_ready),
        .rsp_dest         (rsp_dest),
        .rsp_content      (rsp_content),
        .rsp_content_len  (rsp_content_len),
        .rsp_timeout      (rsp_timeout)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    // Model: id of the requester granted most recently (1 after reset)
    bit model_last = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " core_prefix"}, core_prefix, 0);
        check({tag, " core_len"}, 64'(core_len), 0);
        check({tag, " out_bit"}, 64'(core_out_bit), 0);
        check({tag, " rsp_valid"}, 64'(rsp_valid), 0);
        check({tag, " rsp_dest"}, 64'(rsp_dest), 0);
        check({tag, " rsp_content"}, rsp_content, 0);
        check({tag, " rsp_len"}, 64'(rsp_content_len), 0);
        check({tag, " rsp_timeout"}, 64'(rsp_timeout), 0);
        check({tag, " mcu_ready"}, 64'(mcu_req_ready), 0);
        check({tag, " if_ready"}, 64'(if_req_ready), 0);
    endtask

    task automatic do_reset();
        mcu_req_valid = 1'b0;
        if_req_valid  = 1'b0;
        core_done     = 1'b0;
        rsp_ready     = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b0;
        model_last = 1'b1;
    endtask

    // One full transaction. d = WAIT cycle (1-based) carrying core_done;
    // spur pulses a bogus core_done during the ISSUE cycle.
    task automatic run_txn(input bit mv, input bit iv,
                           input logic [PW-1:0] pm, input logic [LW-1:0] lm,
                           input logic [PW-1:0] pi, input logic [LW-1:0] li,
                           input int d, input bit spur,
                           input logic [CW-1:0] cont, input logic [CLW-1:0] cl,
                           input int stall);
        bit             win;
        bit             tmo;
        int             rsp_at;
        logic [PW-1:0]  epfx;
        logic [LW-1:0]  elen;
        win  = (mv && iv) ? !model_last : iv;
        epfx = win ? pi : pm;
        elen = win ? li : lm;
        tmo    = TMO_EN && (d > TMO);
        rsp_at = tmo ? TMO : d;

        mcu_req_valid = mv;  mcu_prefix = pm;  mcu_len = lm;
        if_req_valid  = iv;  if_prefix  = pi;  if_len  = li;
        rsp_ready = 1'b0;
        #1;
        check("grant mcu_ready", 64'(mcu_req_ready), 64'(!win));
        check("grant if_ready", 64'(if_req_ready), 64'(win));
        tick();
        model_last = win;
        // Requesters may raise new requests while busy; none may be granted
        mcu_req_valid = 1'($urandom);
        if_req_valid  = 1'($urandom);
        mcu_prefix = {$urandom, $urandom};
        if_prefix  = {$urandom, $urandom};
        check("issue out_bit", 64'(core_out_bit), 1);
        check("issue prefix", core_prefix, epfx);
        check("issue len", 64'(core_len), 64'(elen));
        check("issue rsp_valid", 64'(rsp_valid), 0);

        for (int i = 0; i <= rsp_at; i++) begin
            if (i == 0) begin
                core_done        = spur;
                core_content     = ~cont;
                core_content_len = ~cl;
            end else if (i == d) begin
                core_done        = 1'b1;
                core_content     = cont;
                core_content_len = cl;
            end else begin
                core_done        = 1'b0;
                core_content     = {$urandom, $urandom};
                core_content_len = 8'($urandom);
            end
            tick();
            if (i < rsp_at) begin
                check("wait rsp_valid", 64'(rsp_valid), 0);
                check("wait out_bit", 64'(core_out_bit), 0);
                check("wait no ready", 64'(mcu_req_ready | if_req_ready), 0);
                check("wait prefix stable", core_prefix, epfx);
                check("wait len stable", 64'(core_len), 64'(elen));
            end
        end
        core_done = 1'b0;

        check("rsp valid", 64'(rsp_valid), 1);
        check("rsp dest", 64'(rsp_dest), 64'(win));
        check("rsp content", rsp_content, tmo ? 64'd0 : cont);
        check("rsp len", 64'(rsp_content_len), tmo ? 64'd0 : 64'(cl));
        check("rsp timeout", 64'(rsp_timeout), 64'(tmo));
        for (int s = 0; s < stall; s++) begin
            tick();
            check("stall rsp_valid", 64'(rsp_valid), 1);
            check("stall no ready", 64'(mcu_req_ready | if_req_ready), 0);
            check("stall content", rsp_content, tmo ? 64'd0 : cont);
            check("stall dest", 64'(rsp_dest), 64'(win));
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post rsp_valid", 64'(rsp_valid), 0);
        mcu_req_valid = 1'b0;
        if_req_valid  = 1'b0;
    endtask

    initial begin
        bit mv;
        bit iv;
        int d;

        do_reset();

        // Single MCU request with backpressure on the response
        run_txn(1'b1, 1'b0, 64'd28, 5'd5, {$urandom, $urandom}, 5'($urandom),
                4, 1'b0, 64'hAB, 8'd8, 3);

        // Continuous contention alternates MCU, IF, MCU, IF after reset
        do_reset();
        for (int k = 0; k < 4; k++) begin
            run_txn(1'b1, 1'b1, {$urandom, $urandom}, 5'($urandom),
                    {$urandom, $urandom}, 5'($urandom),
                    1 + int'($urandom_range(0, 3)), 1'b0,
                    {$urandom, $urandom}, 8'($urandom), 0);
            check("rr dest pattern", 64'(rsp_dest), 64'(k % 2));
        end

        // Stray core_done in IDLE is ignored
        core_done    = 1'b1;
        core_content = 64'hDEAD;
        tick();
        core_done = 1'b0;
        check("idle done rsp_valid", 64'(rsp_valid), 0);
        check("idle done out_bit", 64'(core_out_bit), 0);
        // Stray core_done in ISSUE is ignored too
        run_txn(1'b0, 1'b1, {$urandom, $urandom}, 5'($urandom),
                {$urandom, $urandom}, 5'($urandom), 3, 1'b1,
                {$urandom, $urandom}, 8'($urandom), 1);

        // Reset while in WAIT aborts the transaction
        mcu_req_valid = 1'b1;
        mcu_prefix    = {$urandom, $urandom};
        mcu_len       = 5'($urandom);
        tick();
        mcu_req_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_last = 1'b1;
        check_all_zero("reset in wait");
        tick();
        check("after reset out_bit", 64'(core_out_bit), 0);
        check("after reset rsp_valid", 64'(rsp_valid), 0);
        run_txn(1'b1, 1'b1, {$urandom, $urandom}, 5'($urandom),
                {$urandom, $urandom}, 5'($urandom), 2, 1'b0,
                {$urandom, $urandom}, 8'($urandom), 0);

        // Long core latency: aborts with the timeout option, waits otherwise
        run_txn(1'b0, 1'b1, {$urandom, $urandom}, 5'($urandom),
                {$urandom, $urandom}, 5'($urandom), 101, 1'b0,
                {$urandom, $urandom}, 8'($urandom), 1);
        // core_done on the last allowed WAIT cycle is a normal response
        run_txn(1'b1, 1'b0, {$urandom, $urandom}, 5'($urandom),
                {$urandom, $urandom}, 5'($urandom), 16, 1'b0,
                {$urandom, $urandom}, 8'($urandom), 0);

        // Randomized traffic
        for (int k = 0; k < 40; k++) begin
            mv = 1'($urandom);
            iv = 1'($urandom);
            if (!mv && !iv) begin
                mv = 1'b1;
            end
            d = 1 + int'($urandom_range(0, 5));
            if ($urandom_range(0, 9) == 0) begin
                d = 18 + int'($urandom_range(0, 4));
            end
            run_txn(mv, iv, {$urandom, $urandom}, 5'($urandom),
                    {$urandom, $urandom}, 5'($urandom), d, 1'($urandom),
                    {$urandom, $urandom}, 8'($urandom),
                    int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_ndn_lookup_arbiter

`default_nettype wire
